// File: rtl/lbus_mko_pkg.sv
// ---------------------------------------------------------------------------
// lbus_mko_pkg
//   Shared definitions for the MKO local-bus initiator:
//     - lbus_state_e : access sequencer states
//     - MKO0..MKO4, MKO_INT_REG : window codes carried in address bits [15:13]
//     - TMO_RDATA    : read value returned when the slave never acknowledges
//     - CNT_W        : width of the wait/hold counter
//     - win_sel()    : extracts the window code from a bus address
// ---------------------------------------------------------------------------
package lbus_mko_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        HOLD,
        RELEASE,
        RESP
    } lbus_state_e;

    localparam logic [2:0] MKO0        = 3'b000;
    localparam logic [2:0] MKO1        = 3'b001;
    localparam logic [2:0] MKO2        = 3'b010;
    localparam logic [2:0] MKO3        = 3'b011;
    localparam logic [2:0] MKO4        = 3'b100;
    localparam logic [2:0] MKO_INT_REG = 3'b101;

    localparam logic [15:0] TMO_RDATA = 16'hFFFF;

    // Wide enough for TIMEOUT_CYCLES up to 255; the counter saturates there.
    localparam int CNT_W = 8;

    function automatic logic [2:0] win_sel(input logic [15:0] addr);
        return addr[15:13];
    endfunction

endpackage

// File: rtl/lbus_mko_master_if.sv
// ---------------------------------------------------------------------------
// lbus_mko_master_if
//   Bundles the requester handshake and the local-bus signals of the MKO
//   initiator.
//     master modport : the initiator's view (drives bus + response)
//     slave  modport : requester/slave view (drives request + acknowledge)
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata, rsp_timeout
//   Bus     : Adr_slave_i_lbus_reg, We_slave_i_lbus_reg, Dat_slave_io_lbus,
//             ack_access_str, ack_access_reg_3, Dat_slave_o_lbus, ack_set_reg
// ---------------------------------------------------------------------------
interface lbus_mko_master_if #(
    parameter int WB_DATA_WIDTH = 16,
    parameter int WB_ADDR_WIDTH = 16
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [WB_ADDR_WIDTH-1:0] req_addr;
    logic [WB_DATA_WIDTH-1:0] req_wdata;

    logic                     rsp_valid;
    logic [WB_DATA_WIDTH-1:0] rsp_rdata;
    logic                     rsp_timeout;

    logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg;
    logic                     We_slave_i_lbus_reg;
    logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus;
    logic                     ack_access_str;
    logic                     ack_access_reg_3;
    logic [WB_DATA_WIDTH-1:0] Dat_slave_o_lbus;
    logic                     ack_set_reg;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        output Adr_slave_i_lbus_reg, We_slave_i_lbus_reg, Dat_slave_io_lbus,
        output ack_access_str, ack_access_reg_3,
        input  Dat_slave_o_lbus, ack_set_reg
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        input  Adr_slave_i_lbus_reg, We_slave_i_lbus_reg, Dat_slave_io_lbus,
        input  ack_access_str, ack_access_reg_3,
        output Dat_slave_o_lbus, ack_set_reg
    );

endinterface

// File: rtl/lbus_wait_counter.sv
// ---------------------------------------------------------------------------
// lbus_wait_counter
//   Saturating cycle counter for the acknowledge wait and the window hold.
//     CLK_32, RESET_N : clock, async active-low reset
//     clr             : synchronous clear (takes priority over inc)
//     inc             : count this cycle
//     hold_done       : count >= HOLD_CYCLES-1
//     tmo_hit         : count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module lbus_wait_counter #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic CLK_32,
    input  logic RESET_N,
    input  logic clr,
    input  logic inc,
    output logic hold_done,
    output logic tmo_hit
);
    import lbus_mko_pkg::*;

    logic [CNT_W-1:0] cnt;

    // Saturate at all-ones so a stuck HOLD can never wrap back below the
    // hold threshold.
    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign hold_done = (cnt >= CNT_W'(HOLD_CYCLES - 1));
    assign tmo_hit   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lbus_mko_master.sv
// ---------------------------------------------------------------------------
// lbus_mko_master
//   Local-bus initiator for the MKO slave windows. Takes one request at a
//   time, presents address/we/data, fires a one-cycle access strobe, holds
//   the access window until the slave acknowledges (or the wait times out),
//   then returns read data and a timeout flag with a one-cycle rsp_valid.
//     CLK_32  : 32 MHz local-bus clock
//     RESET_N : asynchronous active-low reset
//     bus     : lbus_mko_master_if.master (request, response and bus pins)
//
//   Sequence: IDLE -> SETUP -> STROBE -> WAIT -> HOLD -> RELEASE -> RESP
//   (timeout skips HOLD). The counter is cleared leaving STROBE, so it reads
//   0 in the first WAIT cycle and counts WAIT+HOLD cycles after the strobe.
// ---------------------------------------------------------------------------
module lbus_mko_master #(
    parameter int WB_DATA_WIDTH  = 16,
    parameter int WB_ADDR_WIDTH  = 16,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLK_32,
    input  logic                  RESET_N,
    lbus_mko_master_if.master     bus
);
    import lbus_mko_pkg::*;

    lbus_state_e state;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        hold_done;
    logic        tmo_hit;

    assign cnt_clr       = (state == STROBE);
    assign cnt_inc       = (state == WAIT) || (state == HOLD);
    assign bus.req_ready = (state == IDLE);

    lbus_wait_counter #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .CLK_32    (CLK_32),
        .RESET_N   (RESET_N),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .hold_done (hold_done),
        .tmo_hit   (tmo_hit)
    );

    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            state                    <= IDLE;
            bus.Adr_slave_i_lbus_reg <= '0;
            bus.We_slave_i_lbus_reg  <= 1'b0;
            bus.Dat_slave_io_lbus    <= '0;
            bus.ack_access_str       <= 1'b0;
            bus.ack_access_reg_3     <= 1'b0;
            bus.rsp_valid            <= 1'b0;
            bus.rsp_rdata            <= '0;
            bus.rsp_timeout          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Bus fields are latched here and left untouched until
                    // the next accept, so they are stable a full cycle ahead
                    // of the strobe.
                    if (bus.req_valid) begin
                        bus.Adr_slave_i_lbus_reg <= bus.req_addr;
                        bus.We_slave_i_lbus_reg  <= bus.req_we;
                        bus.Dat_slave_io_lbus    <= bus.req_wdata;
                        state                    <= SETUP;
                    end
                end
                SETUP: begin
                    bus.ack_access_str   <= 1'b1;
                    bus.ack_access_reg_3 <= 1'b1;
                    state                <= STROBE;
                end
                STROBE: begin
                    bus.ack_access_str <= 1'b0;
                    state              <= WAIT;
                end
                WAIT: begin
                    // Acknowledge is tested first so it wins a tie with the
                    // final timeout cycle.
                    if (bus.ack_set_reg) begin
                        bus.rsp_rdata   <= bus.Dat_slave_o_lbus;
                        bus.rsp_timeout <= 1'b0;
                        state           <= HOLD;
                    end else if (tmo_hit) begin
                        bus.rsp_rdata        <= WB_DATA_WIDTH'(TMO_RDATA);
                        bus.rsp_timeout      <= 1'b1;
                        bus.ack_access_reg_3 <= 1'b0;
                        state                <= RELEASE;
                    end
                end
                HOLD: begin
                    // Keeps the window open long enough for the slave's
                    // clk_16 STRBD/SELECT generation; a late acknowledge
                    // already satisfies this and leaves after one cycle.
                    if (hold_done) begin
                        bus.ack_access_reg_3 <= 1'b0;
                        state                <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Window is low this cycle so the slave drops its ack.
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.ack_access_str   <= 1'b0;
                    bus.ack_access_reg_3 <= 1'b0;
                    bus.rsp_valid        <= 1'b0;
                    state                <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbus_mko_master.sv
// ---------------------------------------------------------------------------
// tb_lbus_mko_master
//   Self-checking bench: directed vector table, randomized accesses checked
//   against a window/latency model, back-to-back held request and reset
//   during WAIT. Cycle k is the state after the k-th edge following accept.
// ---------------------------------------------------------------------------
module tb_lbus_mko_master;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int HOLD = 4;
    localparam int TMO  = 64;

    logic CLK_32  = 1'b0;
    logic RESET_N = 1'b0;

    lbus_mko_master_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

    lbus_mko_master #(
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK_32  (CLK_32),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK_32 = ~CLK_32;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave responder ----------------
    // Asserts ack cfg_delay cycles after the strobe cycle and keeps it while
    // the window is high; cfg_delay < 1 means never acknowledge.
    int          cfg_delay = -1;
    logic [15:0] cfg_rd    = 16'h0;

    initial begin
        int since;
        since                = 0;
        bus.ack_set_reg      = 1'b0;
        bus.Dat_slave_o_lbus = 16'h0;
        forever begin
            @(posedge CLK_32);
            #1;
            if (bus.ack_access_str) since = 0;
            else if (bus.ack_access_reg_3) since++;
            if (bus.ack_access_reg_3 && !bus.ack_access_str && cfg_delay >= 1 && since >= cfg_delay) begin
                bus.ack_set_reg      = 1'b1;
                bus.Dat_slave_o_lbus = cfg_rd;
            end else begin
                bus.ack_set_reg      = 1'b0;
                bus.Dat_slave_o_lbus = ~cfg_rd;
            end
        end
    end

    // ---------------- reference model ----------------
    // The window stays high for the strobe cycle plus at least HOLD cycles,
    // and at least one cycle past the acknowledge; without an ack inside the
    // TMO wait cycles it is the strobe plus TMO cycles. rsp follows the
    // window by one release cycle.
    function automatic int exp_reg3_w(input int d);
        if (d >= 1 && d <= TMO) return 1 + ((d + 1 > HOLD) ? d + 1 : HOLD);
        return 1 + TMO;
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        int          delay;
        logic [15:0] exp_rdata;
        logic        exp_tmo;
        int          exp_reg3;
        int          exp_rsp;
    } vec_t;

    // Observe one access from the cycle after its accept edge to rsp_valid.
    task automatic observe(output int str_k, output int str_n, output int reg3_n,
                           output int rsp_k, output int rdy_n,
                           output logic [15:0] adr0, output logic [15:0] dat0,
                           output logic we0, output logic pre0,
                           output logic [15:0] rdata, output logic tmo);
        str_k = -1; str_n = 0; reg3_n = 0; rsp_k = -1; rdy_n = 0;
        adr0 = 16'h0; dat0 = 16'h0; we0 = 1'b0; pre0 = 1'b0; rdata = 16'h0; tmo = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK_32);
            if (k == 0) begin
                adr0 = bus.Adr_slave_i_lbus_reg;
                dat0 = bus.Dat_slave_io_lbus;
                we0  = bus.We_slave_i_lbus_reg;
                pre0 = !bus.ack_access_str && !bus.ack_access_reg_3;
            end
            if (bus.ack_access_str) begin
                if (str_k < 0) str_k = k;
                str_n++;
            end
            if (bus.ack_access_reg_3) reg3_n++;
            if (bus.req_ready) rdy_n++;
            if (bus.rsp_valid) begin
                rsp_k = k;
                rdata = bus.rsp_rdata;
                tmo   = bus.rsp_timeout;
                break;
            end
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        int str_k, str_n, reg3_n, rsp_k, rdy_n;
        logic [15:0] adr0, dat0, rdata;
        logic we0, pre0, tmo;
        cfg_delay = v.delay;
        cfg_rd    = v.rd;
        @(posedge CLK_32); #1;
        bus.req_we = v.we; bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
        @(negedge CLK_32);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(1));
        @(posedge CLK_32); #1;
        bus.req_valid = 1'b0;
        observe(str_k, str_n, reg3_n, rsp_k, rdy_n, adr0, dat0, we0, pre0, rdata, tmo);
        check({tag, ".adr"},     32'(adr0),   32'(v.addr));
        check({tag, ".we"},      32'(we0),    32'(v.we));
        check({tag, ".dat"},     32'(dat0),   32'(v.wdata));
        check({tag, ".pre_str"}, 32'(pre0),   32'(1));
        check({tag, ".str_k"},   32'(str_k),  32'(1));
        check({tag, ".str_n"},   32'(str_n),  32'(1));
        check({tag, ".reg3_w"},  32'(reg3_n), 32'(v.exp_reg3));
        check({tag, ".rsp_k"},   32'(rsp_k),  32'(v.exp_rsp));
        check({tag, ".rdata"},   32'(rdata),  32'(v.exp_rdata));
        check({tag, ".tmo"},     32'(tmo),    32'(v.exp_tmo));
        check({tag, ".busy"},    32'(rdy_n),  32'(0));
        @(negedge CLK_32);
        check({tag, ".rsp_1cyc"}, 32'(bus.rsp_valid), 32'(0));
        check({tag, ".idle_rdy"}, 32'(bus.req_ready), 32'(1));
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   str_k, str_n, reg3_n, rsp_k, rdy_n, nrsp;
        logic [15:0] adr0, dat0, rdata;
        logic we0, pre0, tmo;
        logic ack;

        //            we    addr      wdata     rd        dly  rdata     tmo  reg3 rsp
        tbl[0] = '{1'b1, 16'hA001, 16'h801F, 16'h5A5A,  1, 16'h5A5A, 1'b0,  5,  7};
        tbl[1] = '{1'b0, 16'hA003, 16'h0000, 16'h8015,  1, 16'h8015, 1'b0,  5,  7};
        tbl[2] = '{1'b0, 16'h2000, 16'h0000, 16'h1111, -1, 16'hFFFF, 1'b1, 65, 67};
        tbl[3] = '{1'b0, 16'h4010, 16'h0000, 16'h0BAD, 10, 16'h0BAD, 1'b0, 12, 14};
        tbl[4] = '{1'b1, 16'h6002, 16'h1234, 16'h00C3,  3, 16'h00C3, 1'b0,  5,  7};
        tbl[5] = '{1'b0, 16'h8004, 16'h0000, 16'h7777,  4, 16'h7777, 1'b0,  6,  8};
        tbl[6] = '{1'b0, 16'hA00F, 16'h0000, 16'h4242, 64, 16'h4242, 1'b0, 66, 68};
        tbl[7] = '{1'b0, 16'hA010, 16'h0000, 16'h1357, 65, 16'hFFFF, 1'b1, 65, 67};
        tbl[8] = '{1'b1, 16'hE000, 16'hFFFF, 16'h0001,  2, 16'h0001, 1'b0,  5,  7};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;

        // ---- reset state ----
        #23;
        check("rst.adr",   32'(bus.Adr_slave_i_lbus_reg), 32'(0));
        check("rst.we",    32'(bus.We_slave_i_lbus_reg),  32'(0));
        check("rst.dat",   32'(bus.Dat_slave_io_lbus),    32'(0));
        check("rst.str",   32'(bus.ack_access_str),       32'(0));
        check("rst.reg3",  32'(bus.ack_access_reg_3),     32'(0));
        check("rst.rspv",  32'(bus.rsp_valid),            32'(0));
        check("rst.rdata", 32'(bus.rsp_rdata),            32'(0));
        check("rst.tmo",   32'(bus.rsp_timeout),          32'(0));
        @(negedge CLK_32); RESET_N = 1'b1;
        @(negedge CLK_32);
        check("rst.ready", 32'(bus.req_ready), 32'(1));

        // ---- directed table ----
        foreach (tbl[i]) run_row(tbl[i], $sformatf("vec%0d", i));

        // ---- randomized against model ----
        for (int i = 0; i < 16; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = 16'($urandom);
            v.wdata = 16'($urandom);
            v.rd    = 16'($urandom);
            v.delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 72));
            ack         = (v.delay >= 1 && v.delay <= TMO);
            v.exp_rdata = ack ? v.rd : 16'hFFFF;
            v.exp_tmo   = !ack;
            v.exp_reg3  = exp_reg3_w(v.delay);
            v.exp_rsp   = v.exp_reg3 + 2;
            run_row(v, $sformatf("rnd%0d", i));
        end

        // ---- request held through an access ----
        cfg_delay = 2; cfg_rd = 16'hBEEF;
        @(posedge CLK_32); #1;
        bus.req_we = 1'b1; bus.req_addr = 16'h2222; bus.req_wdata = 16'h0001; bus.req_valid = 1'b1;
        @(posedge CLK_32); #1;
        bus.req_we = 1'b0; bus.req_addr = 16'h3333; bus.req_wdata = 16'h0002;
        observe(str_k, str_n, reg3_n, rsp_k, rdy_n, adr0, dat0, we0, pre0, rdata, tmo);
        check("b2b.a_adr",  32'(adr0),  32'(16'h2222));
        check("b2b.a_busy", 32'(rdy_n), 32'(0));
        check("b2b.a_rsp",  32'(rsp_k), 32'(7));
        @(negedge CLK_32);
        check("b2b.idle_rdy", 32'(bus.req_ready), 32'(1));
        check("b2b.idle_adr", 32'(bus.Adr_slave_i_lbus_reg), 32'(16'h2222));
        @(posedge CLK_32); #1;
        bus.req_valid = 1'b0;
        observe(str_k, str_n, reg3_n, rsp_k, rdy_n, adr0, dat0, we0, pre0, rdata, tmo);
        check("b2b.b_adr",   32'(adr0),  32'(16'h3333));
        check("b2b.b_we",    32'(we0),   32'(0));
        check("b2b.b_str",   32'(str_k), 32'(1));
        check("b2b.b_rsp",   32'(rsp_k), 32'(7));
        check("b2b.b_rdata", 32'(rdata), 32'(16'hBEEF));

        // ---- reset asserted during WAIT ----
        cfg_delay = -1;
        @(posedge CLK_32); #1;
        bus.req_we = 1'b1; bus.req_addr = 16'hC000; bus.req_wdata = 16'h5555; bus.req_valid = 1'b1;
        @(posedge CLK_32); #1;
        bus.req_valid = 1'b0;
        repeat (10) @(negedge CLK_32);
        check("rstw.pre_reg3", 32'(bus.ack_access_reg_3), 32'(1));
        #2 RESET_N = 1'b0;
        #1;
        check("rstw.reg3",  32'(bus.ack_access_reg_3),     32'(0));
        check("rstw.adr",   32'(bus.Adr_slave_i_lbus_reg), 32'(0));
        check("rstw.we",    32'(bus.We_slave_i_lbus_reg),  32'(0));
        check("rstw.dat",   32'(bus.Dat_slave_io_lbus),    32'(0));
        check("rstw.rdata", 32'(bus.rsp_rdata),            32'(0));
        check("rstw.rspv",  32'(bus.rsp_valid),            32'(0));
        @(negedge CLK_32); @(negedge CLK_32);
        RESET_N = 1'b1;
        @(negedge CLK_32);
        check("rstw.ready", 32'(bus.req_ready), 32'(1));
        nrsp = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge CLK_32);
            if (bus.rsp_valid || bus.ack_access_reg_3) nrsp++;
        end
        check("rstw.no_rsp", 32'(nrsp), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
